result_skid_reg: RTL and testbench

//  Parametrised EX->result pipeline register for the out-of-order core.

---
 rtl/result_skid_reg.sv | 181 ++++++++++++++++++
 tb/tb_result_skid_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_skid_reg.sv
// EX->result pipeline register: NUM_CH independent channels, each a valid/ready
// stage backed by a 2-entry skid buffer, with global flush and a drop counter.
module result_skid_reg #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 32,
    parameter int DST_W     = 5,
    parameter int TAG_W     = 5,
    parameter int DROP_NOWE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH-1:0]          in_we,
    input  logic [NUM_CH*DST_W-1:0]    in_dst,
    input  logic [NUM_CH*TAG_W-1:0]    in_tag,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH-1:0]          out_we,
    output logic [NUM_CH*DST_W-1:0]    out_dst,
    output logic [NUM_CH*TAG_W-1:0]    out_tag,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PW = 1 + DST_W + TAG_W + DATA_W;
    localparam int NW = $clog2(NUM_CH + 1);
    localparam int SW = ((CNT_W > NW) ? CNT_W : NW) + 1;
    localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic [NUM_CH-1:0] w_drop_vec;
    logic [NW-1:0]     w_drop_num;
    logic [SW-1:0]     w_cnt_sum;
    logic [CNT_W-1:0]  r_drop_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t         r_state;
            state_t         w_next;
            logic           r_rdy;
            logic           r_vld;
            logic [PW-1:0]  r_main;
            logic [PW-1:0]  r_skid;
            logic [PW-1:0]  w_in_pl;
            logic           w_acc;
            logic           w_pop;
            logic           w_nowe;
            logic           w_store;
            logic           w_main_ld;
            logic           w_main_sel_skid;
            logic           w_skid_ld;

            assign w_in_pl = {in_we[gi],
                              in_dst[gi*DST_W +: DST_W],
                              in_tag[gi*TAG_W +: TAG_W],
                              in_data[gi*DATA_W +: DATA_W]};

            assign w_acc   = in_valid[gi] & r_rdy;
            assign w_pop   = r_vld & out_ready[gi];
            assign w_nowe  = (DROP_NOWE != 0) & ~in_we[gi];
            // A flushed cycle neither stores nor counts the incoming transfer.
            assign w_store = w_acc & ~w_nowe & ~flush;
            assign w_drop_vec[gi] = w_acc & w_nowe & ~flush;

            // State register with ready/valid registered from the next state
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_EMPTY;
                    r_rdy   <= 1'b1;
                    r_vld   <= 1'b0;
                end else begin
                    r_state <= w_next;
                    r_rdy   <= (w_next != ST_FULL);
                    r_vld   <= (w_next != ST_EMPTY);
                end
            end

            // Next-state logic
            always_comb begin
                w_next = r_state;
                if (flush) begin
                    w_next = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: w_next = w_store ? ST_BUSY : ST_EMPTY;
                        ST_BUSY: begin
                            if (w_store && !w_pop) begin
                                w_next = ST_FULL;
                            end else if (!w_store && w_pop) begin
                                w_next = ST_EMPTY;
                            end else begin
                                w_next = ST_BUSY;
                            end
                        end
                        ST_FULL:  w_next = w_pop ? ST_BUSY : ST_FULL;
                        default:  w_next = ST_EMPTY;
                    endcase
                end
            end

            // Payload load strobes for main and skid registers
            always_comb begin
                w_main_ld       = 1'b0;
                w_main_sel_skid = 1'b0;
                w_skid_ld       = 1'b0;
                if (!flush) begin
                    case (r_state)
                        ST_EMPTY: w_main_ld = w_store;
                        ST_BUSY: begin
                            w_main_ld = w_store & w_pop;
                            w_skid_ld = w_store & ~w_pop;
                        end
                        ST_FULL: begin
                            w_main_ld       = w_pop;
                            w_main_sel_skid = w_pop;
                        end
                        default: w_main_ld = 1'b0;
                    endcase
                end else begin
                    w_main_ld = 1'b0;
                end
            end

            // Payload registers; main is never cleared except by reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main <= '0;
                    r_skid <= '0;
                end else begin
                    if (w_main_ld) begin
                        r_main <= w_main_sel_skid ? r_skid : w_in_pl;
                    end
                    if (w_skid_ld) begin
                        r_skid <= w_in_pl;
                    end
                end
            end

            assign in_ready[gi]                   = r_rdy;
            assign out_valid[gi]                  = r_vld;
            assign out_we[gi]                     = r_main[PW-1];
            assign out_dst[gi*DST_W +: DST_W]     = r_main[TAG_W+DATA_W +: DST_W];
            assign out_tag[gi*TAG_W +: TAG_W]     = r_main[DATA_W +: TAG_W];
            assign out_data[gi*DATA_W +: DATA_W]  = r_main[DATA_W-1:0];
        end
    endgenerate

    // Number of channels dropping a we=0 transfer this cycle
    always_comb begin
        w_drop_num = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_drop_num = w_drop_num + NW'(w_drop_vec[k]);
        end
    end

    assign w_cnt_sum = SW'(r_drop_cnt) + SW'(w_drop_num);

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_cnt_sum > CNT_MAX) begin
            r_drop_cnt <= CNT_MAX[CNT_W-1:0];
        end else begin
            r_drop_cnt <= w_cnt_sum[CNT_W-1:0];
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_result_skid_reg.sv
// Bench for result_skid_reg: two 4-channel instances (store-all and drop-we0 with
// a 3-bit counter) share stimulus; a queue scoreboard checks every output cycle.
module tb_result_skid_reg;

    localparam int PW = 43;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic [3:0]   in_valid, in_we, out_ready;
    logic [19:0]  in_dst, in_tag;
    logic [127:0] in_data;

    logic [3:0]   a_ir, a_ov, a_owe, b_ir, b_ov, b_owe;
    logic [19:0]  a_odst, a_otag, b_odst, b_otag;
    logic [127:0] a_odata, b_odata;
    logic [15:0]  a_cnt;
    logic [2:0]   b_cnt;

    logic [PW-1:0] sbq [2][4][$];
    int            cnt_m [2];
    int            cnt_max [2] = '{65535, 7};
    bit            drop_en [2] = '{1'b0, 1'b1};
    int            n_cmp = 0;
    int            n_err = 0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    result_skid_reg #(.NUM_CH(4), .DROP_NOWE(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_ir), .in_we(in_we),
        .in_dst(in_dst), .in_tag(in_tag), .in_data(in_data),
        .out_valid(a_ov), .out_ready(out_ready), .out_we(a_owe),
        .out_dst(a_odst), .out_tag(a_otag), .out_data(a_odata),
        .drop_cnt(a_cnt)
    );

    result_skid_reg #(.NUM_CH(4), .DROP_NOWE(1), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_ir), .in_we(in_we),
        .in_dst(in_dst), .in_tag(in_tag), .in_data(in_data),
        .out_valid(b_ov), .out_ready(out_ready), .out_we(b_owe),
        .out_dst(b_odst), .out_tag(b_otag), .out_data(b_odata),
        .drop_cnt(b_cnt)
    );

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pl(input int ch, input logic [3:0] we,
                                         input logic [19:0] dst, input logic [19:0] tag,
                                         input logic [127:0] data);
        return {we[ch], dst[ch*5 +: 5], tag[ch*5 +: 5], data[ch*32 +: 32]};
    endfunction

    // Compare one instance against its queue model, then advance the model
    task automatic step(input int d, input logic [3:0] ov, input logic [3:0] ir,
                        input logic [3:0] owe, input logic [19:0] odst,
                        input logic [19:0] otag, input logic [127:0] odata,
                        input logic [15:0] cnt);
        cmp($sformatf("dut%0d drop_cnt", d), cnt, cnt_m[d]);
        for (int ch = 0; ch < 4; ch++) begin
            bit ev, er;
            ev = sbq[d][ch].size() != 0;
            er = sbq[d][ch].size() < 2;
            cmp($sformatf("dut%0d ch%0d out_valid", d, ch), ov[ch], ev);
            cmp($sformatf("dut%0d ch%0d in_ready", d, ch), ir[ch], er);
            if (ev) begin
                cmp($sformatf("dut%0d ch%0d payload", d, ch),
                    pl(ch, owe, odst, otag, odata), sbq[d][ch][0]);
            end
            if (rst || flush) begin
                sbq[d][ch].delete();
            end else begin
                if (ev && out_ready[ch]) void'(sbq[d][ch].pop_front());
                if (in_valid[ch] && er) begin
                    if (drop_en[d] && !in_we[ch]) begin
                        if (cnt_m[d] < cnt_max[d]) cnt_m[d]++;
                    end else begin
                        sbq[d][ch].push_back(pl(ch, in_we, in_dst, in_tag, in_data));
                    end
                end
            end
        end
        if (rst) cnt_m[d] = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            step(0, a_ov, a_ir, a_owe, a_odst, a_otag, a_odata, a_cnt);
            step(1, b_ov, b_ir, b_owe, b_odst, b_otag, b_odata, {13'd0, b_cnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 4'd0; in_we = 4'd0; out_ready = 4'd0;
        in_dst = 20'd0; in_tag = 20'd0; in_data = 128'd0;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset out_valid", a_ov, 4'h0);
        cmp("reset in_ready", a_ir, 4'hF);
        cmp("reset out_data", a_odata, 128'd0);
        cmp("reset drop_cnt a", a_cnt, 16'd0);
        cmp("reset drop_cnt b", b_cnt, 3'd0);
        mon_en = 1'b1;
        rst = 1'b0;

        // pass-through
        out_ready = 4'hF; in_we = 4'hF; in_valid = 4'b0001;
        in_tag[4:0] = 5'd3; in_dst[4:0] = 5'd7; in_data[31:0] = 32'hDEADBEEF;
        tick();
        in_valid = 4'd0;
        cmp("pass valid", a_ov[0], 1'b1);
        cmp("pass tag", a_otag[4:0], 5'd3);
        cmp("pass data", a_odata[31:0], 32'hDEADBEEF);
        tick();
        cmp("pass valid drop", a_ov[0], 1'b0);

        // skid: three back-to-back on ch1 with consumer stalled
        out_ready = 4'd0; in_valid = 4'b0010; in_tag[9:5] = 5'd1; in_data[63:32] = 32'h11;
        tick();
        in_tag[9:5] = 5'd2; in_data[63:32] = 32'h22;
        tick();
        cmp("skid ready low", a_ir[1], 1'b0);
        cmp("skid head tag1", a_otag[9:5], 5'd1);
        in_tag[9:5] = 5'd3; in_data[63:32] = 32'h33;
        tick();
        cmp("skid still full", a_ir[1], 1'b0);
        out_ready = 4'b0010;
        tick();
        cmp("skid tag2", a_otag[9:5], 5'd2);
        cmp("skid data2", a_odata[63:32], 32'h22);
        tick();
        in_valid = 4'd0;
        cmp("skid tag3", a_otag[9:5], 5'd3);
        cmp("skid valid3", a_ov[1], 1'b1);
        tick();
        cmp("skid empty", a_ov[1], 1'b0);

        // flush with channel 0 full and a same-cycle input
        out_ready = 4'd0; in_valid = 4'b0001; in_tag[4:0] = 5'd4;
        tick();
        in_tag[4:0] = 5'd5;
        tick();
        cmp("flush pre full", a_ir[0], 1'b0);
        flush = 1'b1; in_tag[4:0] = 5'd6;
        tick();
        flush = 1'b0; in_valid = 4'd0;
        cmp("flush valid", a_ov[0], 1'b0);
        cmp("flush ready", a_ir[0], 1'b1);
        tick();
        cmp("flush entry absent", a_ov[0], 1'b0);

        // we=0 drops: 3 on ch0 and one on ch1 in the first cycle
        out_ready = 4'hF; in_we = 4'd0; in_valid = 4'b0011;
        tick();
        in_valid = 4'b0001;
        tick();
        tick();
        in_valid = 4'd0;
        cmp("drop cnt 4", b_cnt, 3'd4);
        cmp("drop no valid", b_ov, 4'h0);
        cmp("no drop when disabled", a_cnt, 16'd0);
        in_valid = 4'hF;
        tick();
        in_valid = 4'd0;
        cmp("drop cnt saturate", b_cnt, 3'd7);

        // reset mid-operation
        out_ready = 4'd0; in_we = 4'hF; in_valid = 4'b0100; in_data[95:64] = 32'hCAFE0001;
        tick();
        tick();
        in_valid = 4'd0; rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst mid valid", a_ov, 4'h0);
        cmp("rst mid ready", a_ir, 4'hF);
        cmp("rst mid data", a_odata, 128'd0);
        cmp("rst mid cnt", b_cnt, 3'd0);

        // flushed drop is not counted
        in_we = 4'd0; in_valid = 4'b0001; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 4'd0;
        cmp("flush drop uncounted", b_cnt, 3'd0);
        in_valid = 4'b0001;
        tick();
        in_valid = 4'd0;
        cmp("drop after flush", b_cnt, 3'd1);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 4'($urandom);
            in_we     = 4'($urandom) | 4'($urandom);
            out_ready = 4'($urandom);
            in_dst    = 20'($urandom);
            in_tag    = 20'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        in_valid = 4'd0; flush = 1'b0; rst = 1'b0; out_ready = 4'hF;
        repeat (4) tick();
        cmp("drain a", a_ov, 4'h0);
        cmp("drain b", b_ov, 4'h0);
        for (int ch = 0; ch < 4; ch++) begin
            cmp($sformatf("sb empty ch%0d", ch), sbq[0][ch].size() + sbq[1][ch].size(), 0);
        end
        @(posedge clk);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
